reg_file_arbiter: RTL and testbench

//  Round-robin arbiter sharing one 2^W x N register file between two requesters.

---
 rtl/reg_file_arbiter.sv | 134 +++++++++++++
 tb/tb_reg_file_arbiter.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_arbiter.sv
// Purpose: round-robin arbiter sharing one 2**W x N register file between two requesters, plus a zero-fill scrub sequencer.
// Latency: grant and write are combinational in the request cycle; read data is registered, with rvalidX one cycle after the grant.
// Backpressure: a request is held until it is granted; a scrub stalls all grants for 2**W cycles. Option macro: ARB_FIXED_PRIO_EN.
module reg_file_arbiter #(
    parameter int N = 8,
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         req0,
    input  logic         req1,
    input  logic         we0,
    input  logic         we1,
    input  logic [W-1:0] addr0,
    input  logic [W-1:0] addr1,
    input  logic [N-1:0] wdata0,
    input  logic [N-1:0] wdata1,
    output logic         gnt0,
    output logic         gnt1,
    output logic         rvalid0,
    output logic         rvalid1,
    output logic [N-1:0] rdata0,
    output logic [N-1:0] rdata1,
    input  logic         scrub_req,
    output logic         scrub_busy,
    output logic         rf_wr_en,
    output logic [W-1:0] rf_w_addr,
    output logic [N-1:0] rf_w_data,
    output logic [W-1:0] rf_r_addr,
    input  logic [N-1:0] rf_r_data
);

    typedef enum logic {
        IDLE  = 1'b0,
        SCRUB = 1'b1
    } state_t;

    state_t       state;
    state_t       state_nxt;
    logic [W-1:0] cnt;
    logic [W-1:0] cnt_nxt;
    logic         pick1;

`ifdef ARB_FIXED_PRIO_EN
    // Requester 0 wins every tie; no pointer is kept.
    assign pick1 = req1 & ~req0;
`else
    logic last;

    // Requester 1 wins a tie only when requester 0 was granted last.
    assign pick1 = req1 & (~req0 | ~last);

    // Last-grant pointer moves on every grant issued.
    always_ff @(posedge clk) begin
        if (clr) begin
            last <= 1'b1;
        end else if (gnt0 | gnt1) begin
            last <= gnt1;
        end
    end
`endif

    // State, scrub counter and registered read returns.
    always_ff @(posedge clk) begin
        if (clr) begin
            state   <= IDLE;
            cnt     <= '0;
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
            rdata0  <= '0;
            rdata1  <= '0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            rvalid0 <= gnt0 & ~we0;
            rvalid1 <= gnt1 & ~we1;
            if (gnt0 && !we0) begin
                rdata0 <= rf_r_data;
            end
            if (gnt1 && !we1) begin
                rdata1 <= rf_r_data;
            end
        end
    end

    // Next state, grants and register-file port drive; everything idles to 0 under clr.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        gnt0      = 1'b0;
        gnt1      = 1'b0;
        rf_wr_en  = 1'b0;
        rf_w_addr = '0;
        rf_w_data = '0;
        rf_r_addr = '0;
        if (!clr) begin
            case (state)
                IDLE: begin
                    if (scrub_req) begin
                        // Scrub wins the cycle it is requested; pending accesses wait.
                        state_nxt = SCRUB;
                        cnt_nxt   = '0;
                    end else if (req0 || req1) begin
                        gnt0 = ~pick1;
                        gnt1 = pick1;
                        if (pick1 ? we1 : we0) begin
                            rf_wr_en  = 1'b1;
                            rf_w_addr = pick1 ? addr1 : addr0;
                            rf_w_data = pick1 ? wdata1 : wdata0;
                        end else begin
                            rf_r_addr = pick1 ? addr1 : addr0;
                        end
                    end
                end
                SCRUB: begin
                    rf_wr_en  = 1'b1;
                    rf_w_addr = cnt;
                    rf_w_data = '0;
                    // Counter wraps back to 0 naturally after the last entry.
                    cnt_nxt   = cnt + 1'b1;
                    if (&cnt) begin
                        state_nxt = IDLE;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    assign scrub_busy = (state == SCRUB);

endmodule

// File: tb/tb_reg_file_arbiter.sv
// Purpose: randomized and directed bench for reg_file_arbiter against a behavioural model with its own register file.
// Latency: inputs driven 1ns after posedge, outputs sampled on negedge, model advanced at posedge.
// Backpressure: the bench holds each request until the model says it was granted.
module tb_reg_file_arbiter;

    localparam int N = 8;
    localparam int W = 2;
    localparam int DEPTH = 1 << W;

    logic         clk = 1'b0;
    logic         clr;
    logic         req0, req1, we0, we1;
    logic [W-1:0] addr0, addr1;
    logic [N-1:0] wdata0, wdata1;
    logic         gnt0, gnt1, rvalid0, rvalid1;
    logic [N-1:0] rdata0, rdata1;
    logic         scrub_req, scrub_busy;
    logic         rf_wr_en;
    logic [W-1:0] rf_w_addr, rf_r_addr;
    logic [N-1:0] rf_w_data, rf_r_data;
    logic         mem_zero;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    reg_file_arbiter #(.N(N), .W(W)) dut (
        .clk(clk), .clr(clr),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata0(rdata0), .rdata1(rdata1),
        .scrub_req(scrub_req), .scrub_busy(scrub_busy),
        .rf_wr_en(rf_wr_en), .rf_w_addr(rf_w_addr), .rf_w_data(rf_w_data),
        .rf_r_addr(rf_r_addr), .rf_r_data(rf_r_data)
    );

    // Register file the arbiter drives; zeroed once at start so every read is defined.
    logic [N-1:0] rf_mem [DEPTH];
    always @(posedge clk) begin
        if (mem_zero) begin
            for (int i = 0; i < DEPTH; i++) rf_mem[i] <= '0;
        end else if (rf_wr_en) begin
            rf_mem[rf_w_addr] <= rf_w_data;
        end
    end
    assign rf_r_data = rf_mem[rf_r_addr];

    // Behavioural model state.
    logic [N-1:0] m_mem [DEPTH];
    int           m_left;      // scrub writes still to do
    int           m_last;      // requester granted most recently
    bit           m_rst_seen;
    bit           m_rv [2];
    logic [N-1:0] m_rd [2];
    // Model expectations for the current cycle.
    int           e_who;       // -1 none, 0 or 1
    bit           e_wr;
    logic [W-1:0] e_waddr, e_raddr;
    logic [N-1:0] e_wdata;
    // DUT values observed in the latest cycle.
    logic o_gnt0, o_gnt1, o_wr, o_rv0, o_rv1, o_busy;
    logic [W-1:0] o_waddr;
    logic [N-1:0] o_wdata, o_rd0, o_rd1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected combinational behaviour from the current inputs and model state.
    task automatic model_comb();
        e_who   = -1;
        e_wr    = 0;
        e_waddr = '0;
        e_wdata = '0;
        e_raddr = '0;
        if (clr) return;
        if (m_left > 0) begin
            e_wr    = 1;
            e_waddr = W'(DEPTH - m_left);
            e_wdata = '0;
        end else if (!scrub_req) begin
            if (req0 && req1) begin
`ifdef ARB_FIXED_PRIO_EN
                e_who = 0;
`else
                e_who = 1 - m_last;
`endif
            end else if (req0) e_who = 0;
            else if (req1) e_who = 1;
            if (e_who == 0) begin
                if (we0) begin e_wr = 1; e_waddr = addr0; e_wdata = wdata0; end
                else e_raddr = addr0;
            end else if (e_who == 1) begin
                if (we1) begin e_wr = 1; e_waddr = addr1; e_wdata = wdata1; end
                else e_raddr = addr1;
            end
        end
    endtask

    // Advance the model across one clock edge.
    task automatic model_edge();
        bit rd_grant;
        if (clr) begin
            m_left = 0; m_last = 1; m_rst_seen = 1;
            m_rv[0] = 0; m_rv[1] = 0; m_rd[0] = '0; m_rd[1] = '0;
            return;
        end
        rd_grant = (e_who >= 0) && !e_wr;
        m_rv[0] = rd_grant && (e_who == 0);
        m_rv[1] = rd_grant && (e_who == 1);
        if (rd_grant) m_rd[e_who] = m_mem[e_raddr];
        if (e_wr) m_mem[e_waddr] = e_wdata;
        if (m_left > 0) m_left--;
        else if (scrub_req) m_left = DEPTH;
        if (e_who >= 0) m_last = e_who;
    endtask

    // One clock: check outputs on the negedge, then advance the model at the posedge.
    task automatic cycle();
        model_comb();
        @(negedge clk);
        o_gnt0 = gnt0; o_gnt1 = gnt1; o_wr = rf_wr_en; o_waddr = rf_w_addr;
        o_wdata = rf_w_data; o_rv0 = rvalid0; o_rv1 = rvalid1; o_rd0 = rdata0;
        o_rd1 = rdata1; o_busy = scrub_busy;
        chk("gnt0", 32'(gnt0), 32'(e_who == 0));
        chk("gnt1", 32'(gnt1), 32'(e_who == 1));
        chk("rf_wr_en", 32'(rf_wr_en), 32'(e_wr));
        if (e_wr) begin
            chk("rf_w_addr", 32'(rf_w_addr), 32'(e_waddr));
            chk("rf_w_data", 32'(rf_w_data), 32'(e_wdata));
        end
        chk("rf_r_addr", 32'(rf_r_addr), 32'(e_raddr));
        if (m_rst_seen) begin
            chk("scrub_busy", 32'(scrub_busy), 32'(m_left > 0));
            chk("rvalid0", 32'(rvalid0), 32'(m_rv[0]));
            chk("rvalid1", 32'(rvalid1), 32'(m_rv[1]));
            chk("rdata0", 32'(rdata0), 32'(m_rd[0]));
            chk("rdata1", 32'(rdata1), 32'(m_rd[1]));
        end
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle_inputs();
        clr = 0; req0 = 0; req1 = 0; we0 = 0; we1 = 0; scrub_req = 0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    endtask

    initial begin
        logic [3:0] seq;
        logic [3:0] seq_exp;
        idle_inputs();
        clr = 1; mem_zero = 1;
        for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
        m_left = 0; m_last = 1; m_rst_seen = 0;
        m_rv[0] = 0; m_rv[1] = 0; m_rd[0] = '0; m_rd[1] = '0;
        @(posedge clk); #1;
        cycle();
        mem_zero = 0;
        cycle();
        chk("reset_busy", 32'(o_busy), 32'd0);
        chk("reset_rvalid0", 32'(o_rv0), 32'd0);
        clr = 0;

        // Single write from requester 0.
        req0 = 1; we0 = 1; addr0 = 2'd1; wdata0 = 8'hA5;
        cycle();
        chk("t1_gnt0", 32'(o_gnt0), 32'd1);
        chk("t1_wr_en", 32'(o_wr), 32'd1);
        chk("t1_w_addr", 32'(o_waddr), 32'd1);
        chk("t1_w_data", 32'(o_wdata), 32'hA5);
        req0 = 0;

        // Requester 1 reads it back.
        req1 = 1; we1 = 0; addr1 = 2'd1;
        cycle();
        chk("t2_gnt1", 32'(o_gnt1), 32'd1);
        req1 = 0;
        cycle();
        chk("t2_rvalid1", 32'(o_rv1), 32'd1);
        chk("t2_rdata1", 32'(o_rd1), 32'hA5);
        chk("t2_rvalid0", 32'(o_rv0), 32'd0);

        // Tie held for four cycles right after reset.
        clr = 1; cycle(); clr = 0;
        req0 = 1; we0 = 1; addr0 = 2'd2; wdata0 = 8'h11;
        req1 = 1; we1 = 1; addr1 = 2'd3; wdata1 = 8'h22;
        for (int i = 0; i < 4; i++) begin
            cycle();
            seq[i] = o_gnt0;
        end
`ifdef ARB_FIXED_PRIO_EN
        seq_exp = 4'b1111;
`else
        seq_exp = 4'b0101;
`endif
        chk("t3_gnt0_seq", 32'(seq), 32'(seq_exp));
        req0 = 0; req1 = 0;

        // Scrub aborted by clr in its second cycle.
        scrub_req = 1; cycle(); scrub_req = 0;
        cycle();
        chk("t5_busy_first", 32'(o_busy), 32'd1);
        clr = 1; cycle(); clr = 0;
        cycle();
        chk("t5_busy_after", 32'(o_busy), 32'd0);
        chk("t5_wr_after", 32'(o_wr), 32'd0);
        req0 = 1; we0 = 0; addr0 = 2'd2; cycle(); req0 = 0; cycle();
        chk("t5_entry2", 32'(o_rd0), 32'h11);

        // Scrub pulse with requester 0 reading and held.
        req0 = 1; we0 = 0; addr0 = 2'd0; scrub_req = 1;
        cycle();
        chk("t4_nogrant_req", 32'(o_gnt0), 32'd0);
        scrub_req = 0;
        for (int i = 0; i < DEPTH; i++) begin
            cycle();
            chk("t4_nogrant", 32'(o_gnt0), 32'd0);
            chk("t4_w_addr", 32'(o_waddr), 32'(i));
            chk("t4_busy", 32'(o_busy), 32'd1);
        end
        cycle();
        chk("t4_gnt0_after", 32'(o_gnt0), 32'd1);
        req0 = 0;

        // Read every entry after the completed scrub.
        for (int i = 0; i < DEPTH; i++) begin
            req1 = 1; we1 = 0; addr1 = W'(i);
            cycle();
            req1 = 0;
            cycle();
            chk("t6_rvalid1", 32'(o_rv1), 32'd1);
            chk("t6_rdata1", 32'(o_rd1), 32'd0);
        end

        // Randomized traffic; each request stays up until the model grants it.
        for (int c = 0; c < 600; c++) begin
            clr       = ($urandom_range(0, 99) == 0);
            scrub_req = ($urandom_range(0, 29) == 0);
            cycle();
            if (!req0 || e_who == 0) begin
                req0 = ($urandom_range(0, 2) != 0); we0 = $urandom_range(0, 1);
                addr0 = W'($urandom); wdata0 = N'($urandom);
            end
            if (!req1 || e_who == 1) begin
                req1 = ($urandom_range(0, 2) != 0); we1 = $urandom_range(0, 1);
                addr1 = W'($urandom); wdata1 = N'($urandom);
            end
        end
        idle_inputs();
        cycle();
        cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
